// File: rtl/bus_secondary_serial_tx_if.sv
// bus: single-wire request/response link; secondary drives a, primary answers on b.
interface bus (
    input logic clk
);
    logic a;
    logic b;
    modport secondary (input clk, output a, input b);
    modport primary (input clk, input a, output b);
endinterface

// File: rtl/bus_secondary_serial_tx.sv
// bus_secondary_serial_tx: LSB-first serial word transmitter that waits for an inverted answer on b per bit.
// Define BUS_SEC_CHECK_EN to include the protocol assertions.
module bus_secondary_serial_tx #(
    parameter int   WIDTH      = 8,
    parameter int   TIMEOUT    = 15,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    bus.secondary            intf,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] echo
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DRIVE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ERR   = 3'd4;
    logic [2:0]       state;
    logic [WIDTH-1:0] shift;
    logic [IW-1:0]    idx;
    logic [TW-1:0]    timer;
    logic             a_q;
    logic             match;
    assign intf.a = a_q;
    // Four-state compare so an X or Z answer never counts as a response.
    assign match = (intf.b === !a_q);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            shift <= '0;
            idx   <= '0;
            timer <= '0;
            a_q   <= IDLE_LEVEL;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
            echo  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, ERR: begin
                    a_q <= IDLE_LEVEL;
                    if (start) begin
                        shift <= data;
                        echo  <= '0;
                        idx   <= '0;
                        error <= 1'b0;
                        busy  <= 1'b1;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    a_q   <= shift[0];
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (match) begin
                        echo[idx] <= intf.b;
                        shift     <= shift >> 1;
                        if (idx == IW'(WIDTH - 1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= DRIVE;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                        if (timer == TW'(TIMEOUT - 1)) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            a_q   <= IDLE_LEVEL;
                            state <= ERR;
                        end
                    end
                end
                DONE: begin
                    a_q   <= IDLE_LEVEL;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef BUS_SEC_CHECK_EN
    logic [WIDTH-1:0] word;
    always_ff @(posedge clk) begin
        if (!rst_n)
            word <= '0;
        else if ((state == IDLE || state == ERR) && start)
            word <= data;
    end
    always_comb begin
        assert (intf.clk === clk);
        if (state == DONE) assert (echo === ~word);
        if (state == WAIT) assert (!$isunknown(intf.a));
    end
`else
`endif
endmodule
